// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg: opcodes, FSM states and status-word bit positions shared by the JTAG debug controller.
package jtag_dbg_pkg;
  localparam int INSTR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [INSTR_W-1:0] OP_NOP = 8'h00;
  localparam logic [INSTR_W-1:0] OP_HALT = 8'h01;
  localparam logic [INSTR_W-1:0] OP_RUN = 8'h02;
  localparam logic [INSTR_W-1:0] OP_SETADDR = 8'h03;
  localparam logic [INSTR_W-1:0] OP_WRITE = 8'h04;
  localparam logic [INSTR_W-1:0] OP_READ = 8'h05;
  localparam logic [INSTR_W-1:0] OP_STATUS = 8'h06;
  localparam logic [INSTR_W-1:0] OP_STEP = 8'h07;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_MEM, S_RESP} state_t;
  localparam int ST_HALT = 0;
  localparam int ST_UNKNOWN = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_NOT_HALTED = 3;
endpackage

// File: rtl/jtag_debug_ctrl_if.sv
// jtag_debug_ctrl_if: JTAG port, memory bus and CPU control signals of the debug controller.
interface jtag_debug_ctrl_if;
  import jtag_dbg_pkg::*;
  logic doUpdate;
  logic [INSTR_W-1:0] instrLine;
  logic [DATA_W-1:0] jtagDataIn;
  logic [DATA_W-1:0] jtagDataOut;
  logic jtagWrData;
  logic memReq;
  logic memWr;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic memAck;
  logic cpuHalt;
  logic cpuStep;
  logic busy;
  modport master (
    output doUpdate, instrLine, jtagDataIn, memRdata, memAck,
    input jtagDataOut, jtagWrData, memReq, memWr, memAddr, memWdata, cpuHalt, cpuStep, busy
  );
  modport slave (
    input doUpdate, instrLine, jtagDataIn, memRdata, memAck,
    output jtagDataOut, jtagWrData, memReq, memWr, memAddr, memWdata, cpuHalt, cpuStep, busy
  );
endinterface

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: two-flop synchronizer with a registered rising-edge detect.
module jtag_sync_edge (
  input logic clk,
  input logic rst,
  input logic async_in,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      rise <= 1'b0;
    end else begin
      sr <= {sr[1:0], async_in};
      rise <= sr[1] & ~sr[2];
    end
  end
endmodule

// File: rtl/jtag_debug_ctrl.sv
// jtag_debug_ctrl: executes JTAG debug commands (halt/run/step, halted memory access, status).
// STEP support is built only when JTAG_DBG_STEP_EN is defined.
module jtag_debug_ctrl
  import jtag_dbg_pkg::*;
#(
  parameter int WR_HOLD_CYCLES = 16,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input logic clk,
  input logic rst,
  jtag_debug_ctrl_if.slave bus
);
  localparam int CW = WR_HOLD_CYCLES > 1 ? $clog2(WR_HOLD_CYCLES) : 1;
  state_t state, state_nxt;
  logic upd_rise, cpu_halt, mem_wr, err_not_halted, err_overrun, err_unknown;
  logic is_mem, needs_halt, known, hold_done;
  logic [INSTR_W-1:0] cmd_q;
  logic [DATA_W-1:0] arg_q, addr_q, data_out, status;
  logic [CW-1:0] cnt;
`ifdef JTAG_DBG_STEP_EN
  localparam bit STEP_EN = 1'b1;
  logic cpu_step;
  always_ff @(posedge clk) cpu_step <= !rst && state == S_DECODE && cmd_q == OP_STEP && cpu_halt;
  assign bus.cpuStep = cpu_step;
`else
  localparam bit STEP_EN = 1'b0;
  assign bus.cpuStep = 1'b0;
`endif
  jtag_sync_edge sync (.clk(clk), .rst(rst), .async_in(bus.doUpdate), .rise(upd_rise));
  assign is_mem = cmd_q == OP_WRITE || cmd_q == OP_READ;
  assign needs_halt = is_mem || (STEP_EN && cmd_q == OP_STEP);
  assign known = cmd_q <= OP_STATUS || (STEP_EN && cmd_q == OP_STEP);
  assign hold_done = cnt == CW'(WR_HOLD_CYCLES - 1);
  always_comb begin
    status = '0;
    status[ST_HALT] = cpu_halt;
    status[ST_UNKNOWN] = err_unknown;
    status[ST_OVERRUN] = err_overrun;
    status[ST_NOT_HALTED] = err_not_halted;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == S_IDLE ? (upd_rise ? S_DECODE : S_IDLE)
              : state == S_DECODE ? (is_mem && cpu_halt ? S_MEM : cmd_q == OP_STATUS ? S_RESP : S_IDLE)
              : state == S_MEM ? (bus.memAck ? (mem_wr ? S_IDLE : S_RESP) : S_MEM)
              : (hold_done ? S_IDLE : S_RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
      arg_q <= '0;
      addr_q <= '0;
      data_out <= '0;
      cpu_halt <= HALT_ON_RESET;
      mem_wr <= 1'b0;
      err_not_halted <= 1'b0;
      err_overrun <= 1'b0;
      err_unknown <= 1'b0;
      cnt <= '0;
    end else begin
      if (upd_rise && state == S_IDLE) begin
        cmd_q <= bus.instrLine;
        arg_q <= bus.jtagDataIn;
      end
      if (state == S_DECODE) begin
        cpu_halt <= cmd_q == OP_HALT ? 1'b1 : cmd_q == OP_RUN ? 1'b0 : cpu_halt;
        mem_wr <= cmd_q == OP_WRITE;
        if (cmd_q == OP_SETADDR) addr_q <= arg_q;
        if (needs_halt && !cpu_halt) err_not_halted <= 1'b1;
        if (!known) err_unknown <= 1'b1;
        if (cmd_q == OP_STATUS) begin
          data_out <= status;
          err_not_halted <= 1'b0;
          err_overrun <= 1'b0;
          err_unknown <= 1'b0;
        end
      end
      if (state == S_MEM && bus.memAck) begin
        addr_q <= addr_q + 1'b1;
        if (!mem_wr) data_out <= bus.memRdata;
      end
      cnt <= state == S_RESP ? cnt + 1'b1 : '0;
      // an overrun that lands on a STATUS decode still survives the clear
      if (upd_rise && state != S_IDLE) err_overrun <= 1'b1;
    end
  end
  assign bus.jtagDataOut = data_out;
  assign bus.jtagWrData = state == S_RESP;
  assign bus.memReq = state == S_MEM;
  assign bus.memWr = mem_wr;
  assign bus.memAddr = addr_q;
  assign bus.memWdata = arg_q;
  assign bus.cpuHalt = cpu_halt;
  assign bus.busy = state != S_IDLE;
endmodule

// File: tb/tb_jtag_debug_ctrl.sv
// tb_jtag_debug_ctrl: vector table, overrun/reset sequences and random commands against a command-level model.
module tb_jtag_debug_ctrl;
  import jtag_dbg_pkg::*;
`ifdef JTAG_DBG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  typedef struct {
    bit resp;
    logic [15:0] data;
    bit halt;
    int nacc;
    bit awr;
    logic [15:0] aaddr;
    logic [15:0] adata;
    int steps;
  } exp_t;
  typedef struct {
    logic [7:0] op;
    logic [15:0] arg;
    exp_t e;
  } vec_t;
  typedef struct {
    bit wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit stable;
  } acc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jtag_debug_ctrl_if bus();
  jtag_debug_ctrl #(.WR_HOLD_CYCLES(16), .HALT_ON_RESET(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  acc_t acc_q[$];
  logic [15:0] bus_mem [bit [15:0]];
  bit m_halt, m_nh, m_ov, m_un;
  logic [15:0] m_addr;
  logic [15:0] m_mem [bit [15:0]];
  int r_wc = 0;
  bit r_st, r_w0;
  logic [15:0] r_a0, r_d0;
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic model_exec(input logic [7:0] op, input logic [15:0] arg, output exp_t e);
    e = '{default: 0};
    case (op)
      8'h00: ;
      8'h01: m_halt = 1'b1;
      8'h02: m_halt = 1'b0;
      8'h03: m_addr = arg;
      8'h04: if (m_halt) begin
        m_mem[m_addr] = arg;
        e.nacc = 1; e.awr = 1'b1; e.aaddr = m_addr; e.adata = arg;
        m_addr = m_addr + 16'd1;
      end else m_nh = 1'b1;
      8'h05: if (m_halt) begin
        e.nacc = 1; e.aaddr = m_addr; e.resp = 1'b1;
        e.data = m_mem.exists(m_addr) ? m_mem[m_addr] : dflt(m_addr);
        m_addr = m_addr + 16'd1;
      end else m_nh = 1'b1;
      8'h06: begin
        e.resp = 1'b1;
        e.data = {12'h000, m_nh, m_ov, m_un, m_halt};
        m_nh = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      end
      8'h07: if (!STEP_EN) m_un = 1'b1; else if (m_halt) e.steps = 1; else m_nh = 1'b1;
      default: m_un = 1'b1;
    endcase
    e.halt = m_halt;
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] arg, input int hold,
                         output int wr_cyc, output logic [15:0] cap, output int steps);
    int i = 0;
    acc_q.delete();
    wr_cyc = 0; cap = '0; steps = 0;
    @(negedge clk);
    bus.instrLine = op; bus.jtagDataIn = arg; bus.doUpdate = 1'b1;
    while (i < 400 && (i <= hold || i < 5 || bus.busy)) begin
      @(negedge clk);
      i++;
      if (i == hold) bus.doUpdate = 1'b0;
      wr_cyc += int'(bus.jtagWrData);
      if (bus.jtagWrData) cap = bus.jtagDataOut;
      steps += int'(bus.cpuStep);
    end
    bus.doUpdate = 1'b0;
    if (i >= 400) begin
      checks++; errors++;
      $display("FAIL cmd_timeout op=%0h busy=%0b", op, bus.busy);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic check_cmd(input string tag, input exp_t e, input int wr_cyc, input logic [15:0] cap, input int steps);
    chk({tag, "_wrcyc"}, wr_cyc, e.resp ? 16 : 0);
    if (e.resp) chk({tag, "_data"}, cap, e.data);
    chk({tag, "_halt"}, bus.cpuHalt, e.halt);
    chk({tag, "_nacc"}, acc_q.size(), e.nacc);
    if (acc_q.size() == 1 && e.nacc == 1) begin
      chk({tag, "_addr"}, acc_q[0].addr, e.aaddr);
      chk({tag, "_wr"}, acc_q[0].wr, e.awr);
      chk({tag, "_stable"}, acc_q[0].stable, 1);
      if (e.awr) chk({tag, "_wdata"}, acc_q[0].data, e.adata);
    end
    chk({tag, "_steps"}, steps, e.steps);
  endtask
  function automatic vec_t mk(logic [7:0] op, logic [15:0] arg, bit resp, logic [15:0] data, bit halt,
                              int nacc, bit awr, logic [15:0] aaddr, logic [15:0] adata, int steps);
    vec_t v;
    v.op = op; v.arg = arg;
    v.e = '{resp, data, halt, nacc, awr, aaddr, adata, steps};
    return v;
  endfunction
  // memory responder: acks after ack_delay cycles and records each access
  initial begin
    bus.memAck = 1'b0; bus.memRdata = '0;
    forever begin
      @(negedge clk);
      bus.memAck = 1'b0;
      if (bus.memReq && !rst) begin
        if (r_wc == 0) begin
          r_a0 = bus.memAddr; r_w0 = bus.memWr; r_d0 = bus.memWdata; r_st = 1'b1;
        end else r_st = r_st & (bus.memAddr == r_a0 && bus.memWr == r_w0 && bus.memWdata == r_d0);
        if (r_wc >= ack_delay) begin
          bus.memAck = 1'b1;
          if (r_w0) bus_mem[r_a0] = r_d0;
          else bus.memRdata = bus_mem.exists(r_a0) ? bus_mem[r_a0] : dflt(r_a0);
          acc_q.push_back('{r_w0, r_a0, r_d0, r_st});
          r_wc = 0;
        end else r_wc++;
      end else r_wc = 0;
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vec_t tbl[$];
    exp_t e;
    int wc, st, n, hold;
    logic [15:0] cap, arg;
    logic [7:0] op;
    logic [7:0] pick [16];
    pick = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05, 8'h05, 8'h06, 8'h06, 8'h07, 8'hFF};
    bus.doUpdate = 1'b0; bus.instrLine = '0; bus.jtagDataIn = '0;
    m_halt = 1'b0; m_nh = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_halt", bus.cpuHalt, 0);
    chk("rst_memreq", bus.memReq, 0);
    chk("rst_wrdata", bus.jtagWrData, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dataout", bus.jtagDataOut, 0);
    chk("rst_step", bus.cpuStep, 0);
    chk("rst_addr", bus.memAddr, 0);
    rst = 1'b0;
    tbl.push_back(mk(OP_STATUS, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_HALT, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_SETADDR, 16'h1234, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_WRITE, 16'hBEEF, 0, 16'h0000, 1, 1, 1, 16'h1234, 16'hBEEF, 0));
    tbl.push_back(mk(OP_READ, 16'h0000, 1, 16'h486F, 1, 1, 0, 16'h1235, 0, 0));
    tbl.push_back(mk(OP_SETADDR, 16'h1234, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_READ, 16'h0000, 1, 16'hBEEF, 1, 1, 0, 16'h1234, 0, 0));
    tbl.push_back(mk(OP_SETADDR, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_READ, 16'h0000, 1, 16'hA5A5, 1, 1, 0, 16'hFFFF, 0, 0));
    tbl.push_back(mk(OP_READ, 16'h0000, 1, 16'h5A5A, 1, 1, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(OP_RUN, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_WRITE, 16'h1111, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_STATUS, 16'h0000, 1, 16'h0008, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_STATUS, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h5A, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_STATUS, 16'h0000, 1, 16'h0002, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_HALT, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_STEP, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, STEP_EN ? 1 : 0));
    tbl.push_back(mk(OP_STATUS, 16'h0000, 1, STEP_EN ? 16'h0001 : 16'h0003, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(OP_RUN, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      ack_delay = tbl[i].op == OP_WRITE ? 3 : 1;
      model_exec(tbl[i].op, tbl[i].arg, e);
      run_cmd(tbl[i].op, tbl[i].arg, 3, wc, cap, st);
      check_cmd($sformatf("vec%0d", i), tbl[i].e, wc, cap, st);
    end
    // Update arriving during RESP: HALT must be dropped and errOverrun raised
    model_exec(OP_STATUS, 16'h0000, e);
    @(negedge clk);
    bus.instrLine = OP_STATUS; bus.jtagDataIn = '0; bus.doUpdate = 1'b1;
    repeat (3) @(negedge clk);
    bus.doUpdate = 1'b0;
    n = 0;
    while (!bus.jtagWrData && n < 20) begin @(negedge clk); n++; end
    chk("ovr_resp_started", bus.jtagWrData, 1);
    chk("ovr_status0", bus.jtagDataOut, e.data);
    repeat (2) @(negedge clk);
    bus.instrLine = OP_HALT; bus.doUpdate = 1'b1;
    repeat (3) @(negedge clk);
    bus.doUpdate = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin @(negedge clk); n++; end
    chk("ovr_idle", bus.busy, 0);
    repeat (4) @(negedge clk);
    m_ov = 1'b1;
    chk("ovr_halt_dropped", bus.cpuHalt, 0);
    model_exec(OP_STATUS, 16'h0000, e);
    run_cmd(OP_STATUS, 16'h0000, 3, wc, cap, st);
    check_cmd("ovr_status", e, wc, cap, st);
    chk("ovr_status_word", cap, 16'h0004);
    for (int k = 0; k < 80; k++) begin
      op = pick[$urandom_range(0, 15)];
      if (op == 8'hFF) op = 8'(8 + $urandom_range(0, 247));
      arg = 16'($urandom);
      ack_delay = $urandom_range(0, 4);
      hold = $urandom_range(3, 24);
      model_exec(op, arg, e);
      run_cmd(op, arg, hold, wc, cap, st);
      check_cmd($sformatf("rnd%0d_op%02h", k, op), e, wc, cap, st);
    end
    // reset while a read waits for a slow ack
    run_cmd(OP_HALT, 16'h0000, 3, wc, cap, st);
    ack_delay = 50;
    acc_q.delete();
    bus.instrLine = OP_READ; bus.doUpdate = 1'b1;
    n = 0;
    while (!bus.memReq && n < 20) begin @(negedge clk); n++; end
    chk("rmid_memreq_seen", bus.memReq, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_memreq", bus.memReq, 0);
    chk("rmid_wrdata", bus.jtagWrData, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_halt", bus.cpuHalt, 0);
    @(negedge clk);
    rst = 1'b0; bus.doUpdate = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n += int'(bus.memReq) + int'(bus.busy);
    end
    chk("rmid_quiet", n, 0);
    chk("rmid_no_access", acc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_debug_ctrl.md
# jtag_debug_ctrl

Debug command executor sitting directly downstream of the JTAG port. Consumes the port's update strobe, 8-bit instruction and 16-bit data register, and executes halt/run/step and halted-only memory read/write over the MCU memory bus. Read results and status are loaded back into the JTAG data register through the port's write-data path.

## Interface
Parameters:
- WR_HOLD_CYCLES, 16: clk cycles `jtagWrData` is held high; must exceed one tck period plus 2 synchronizer cycles.
- HALT_ON_RESET, 0: reset value of `cpuHalt`.

Ports:
- clk  in  1  system clock; all state on rising edge. One clock.
- rst  in  1  reset; synchronous, active-high.
- doUpdate  in  1  port Update-state level; asynchronous to clk.
- instrLine  in  8  port instruction register.
- jtagDataIn  in  16  port data register, read side of `dataLine`.
- jtagDataOut  out  16  value driven onto `dataLine` by top-level tristate glue.
- jtagWrData  out  1  drives port `wrData`; loads `jtagDataOut` into the port data register.
- memReq  out  1  bus request.
- memWr  out  1  1 = write, 0 = read; valid with `memReq`.
- memAddr  out  16  word address.
- memWdata  out  16  write data.
- memRdata  in  16  read data; valid with `memAck`.
- memAck  in  1  single-cycle completion.
- cpuHalt  out  1  level; CPU stalls while high.
- cpuStep  out  1  one-cycle pulse; CPU retires one instruction.
- busy  out  1  high in any state but IDLE.

## Operation
- `doUpdate` passes through a 2-flop synchronizer, then a rising-edge detect produces `updRise`. On `updRise`, `instrLine` and `jtagDataIn` are captured into `cmdQ`/`argQ`.
- FSM states: IDLE, DECODE, MEM, RESP.
  - IDLE → DECODE on `updRise`.
  - DECODE executes `cmdQ`.
  - MEM holds the request until ack.
  - RESP holds `jtagWrData` high.
- Opcodes:
  - 0x00 NOP → IDLE.
  - 0x01 HALT: `cpuHalt`=1 → IDLE.
  - 0x02 RUN: `cpuHalt`=0 → IDLE.
  - 0x03 SETADDR: `addrQ`=`argQ` → IDLE.
  - 0x04 WRITE: → MEM with `memWr`=1, `memWdata`=`argQ`.
  - 0x05 READ: → MEM with `memWr`=0.
  - 0x06 STATUS: `jtagDataOut`={12'b0, errNotHalted, errOverrun, errUnknown, cpuHalt}; sticky error bits clear; → RESP.
  - 0x07 STEP: see Configuration.
  - Other opcodes: set `errUnknown` → IDLE.
- WRITE/READ with `cpuHalt`=0: set `errNotHalted`, no bus access → IDLE.
- MEM: `memReq`=1 with `memAddr`=`addrQ`; all bus outputs held stable until `memAck`.
  - On ack: `memReq` drops the same edge, `addrQ` increments (0xFFFF wraps to 0x0000).
  - READ: `jtagDataOut`=`memRdata` → RESP. WRITE → IDLE.
- RESP: `jtagWrData`=1 for exactly WR_HOLD_CYCLES cycles → IDLE. `jtagDataOut` keeps its value until the next RESP.
- `updRise` in any state other than IDLE: command dropped, `errOverrun` set.
- `memAck` outside MEM is ignored.
- Host protocol: after each Update, clock tck in Idle for ≥ WR_HOLD_CYCLES/tck-ratio cycles before shifting data.

## Timing
- Reset values:
  - `cpuHalt`=HALT_ON_RESET.
  - All other outputs 0.
  - `addrQ`=0, error bits 0, FSM=IDLE.
- Reset mid-operation: `memReq` and `jtagWrData` go low on the reset edge. A late `memAck` is ignored.
- Latency:
  - `doUpdate` high at edge N → `updRise` at N+2 → DECODE at N+3.
  - HALT/RUN/SETADDR take effect at N+4.
  - `memReq` first high at N+4.
  - READ with ack at edge M → `jtagWrData` high from M+1 through M+WR_HOLD_CYCLES.
- `doUpdate` held high over many clk cycles produces exactly one `updRise`.

## Configuration
- `JTAG_DBG_STEP_EN` defined:
  - 0x07 STEP with `cpuHalt`=1 pulses `cpuStep` for one cycle at N+4, then IDLE.
  - STEP with `cpuHalt`=0 sets `errNotHalted`.
- Undefined: `cpuStep` is tied to 0, and 0x07 is treated as an unknown opcode (sets `errUnknown`).

## Structure
- Shared package `jtag_dbg_pkg`:
  - opcode constants (OP_NOP … OP_STEP);
  - FSM state encoding;
  - status bit indices.
- One sub-module `jtag_sync_edge`: 2-flop synchronizer plus rising-edge detect, producing `updRise`. Uses the same clk/rst.

## Test plan
- Reset with HALT_ON_RESET=0 → `cpuHalt`=0, `memReq`=0, `jtagWrData`=0, `busy`=0. Then STATUS → `jtagDataOut`=0x0000 with `jtagWrData` high for 16 cycles.
- HALT, SETADDR 0x1234, WRITE 0xBEEF → one bus write at 0x1234 with data 0xBEEF, held through a 3-cycle ack delay. Then READ → address 0x1235 and `jtagDataOut`=`memRdata`.
- SETADDR 0xFFFF, two READs → `memAddr` 0xFFFF, then 0x0000.
- RUN then WRITE → no `memReq`. STATUS → 0x0008; a second STATUS → 0x0000.
- Opcode 0x5A → STATUS 0x0002. `updRise` during RESP → errOverrun, STATUS 0x0004.
- With `JTAG_DBG_STEP_EN`: HALT+STEP → one `cpuStep` pulse. Without it: STEP → no pulse, STATUS 0x0003. Reset asserted mid-MEM → `memReq` low the next cycle.
